muldiv_sequencer: RTL

- Multicycle controller and datapath for the MIPS MULT/DIV instructions in the processor.
- UnidadeControle issues a one-cycle start with the opcode class. The block then sequences an iterative signed shift-add multiplier or a restoring divider over WIDTH cycles.
- It writes the HI/LO result registers and reports completion, letting the control unit hold in a wait state until done.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the control unit (master) and the MULT/DIV sequencer (slave).
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multicycle MIPS MULT/DIV unit: signed shift-add multiplier and restoring divider that
// iterate WIDTH times on operand magnitudes, then sign-fix the result into HI/LO.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned      AccW     = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMultRun,
        StDivRun,
        StFix,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             a_neg_q, a_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             b_zero;
    logic             last_iter;
    logic [WIDTH:0]   mult_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] div_trial;
    logic [AccW-1:0]  prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Negating the most negative value wraps to itself, which is the correct magnitude unsigned.
    assign mag_a     = a_q[WIDTH-1] ? (~a_q + WIDTH'(1)) : a_q;
    assign mag_b     = b_q[WIDTH-1] ? (~b_q + WIDTH'(1)) : b_q;
    assign b_zero    = (b_q == '0);
    assign last_iter = (cnt_q == LastIter);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mult_sum  = {1'b0, acc_q[AccW-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);

    // Divide: acc = {remainder, quotient}; rem_sh is the remainder after the left shift.
    assign rem_sh    = acc_q[AccW-1:WIDTH-1];
    assign rem_ge    = (rem_sh >= {1'b0, opd_q});
    assign div_trial = rem_sh[WIDTH-1:0] - opd_q;

    assign prod_fix  = neg_q   ? (~acc_q + AccW'(1)) : acc_q;
    assign quo_fix   = neg_q   ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    assign rem_fix   = a_neg_q ? (~acc_q[AccW-1:WIDTH] + WIDTH'(1)) : acc_q[AccW-1:WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (op_q && b_zero) begin
                    state_d = StDone;
                end else if (op_q) begin
                    state_d = StDivRun;
                end else begin
                    state_d = StMultRun;
                end
            end
            StMultRun, StDivRun: begin
                if (last_iter) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != StIdle);
        bus.done = (state_q == StDone);
    end

    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        a_neg_d = a_neg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d = bus.op;
                    a_d  = bus.a;
                    b_d  = bus.b;
                    dz_d = 1'b0;
                end
            end
            StLoad: begin
                neg_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                a_neg_d = a_q[WIDTH-1];
                cnt_d   = '0;
                if (op_q) begin
                    acc_d = {{WIDTH{1'b0}}, mag_a};
                    opd_d = mag_b;
                    dz_d  = b_zero;
                end else begin
                    acc_d = {{WIDTH{1'b0}}, mag_b};
                    opd_d = mag_a;
                end
            end
            StMultRun: begin
                acc_d = {mult_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
            end
            StDivRun: begin
                if (rem_ge) begin
                    acc_d = {div_trial, acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[AccW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            StFix: begin
                if (op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[AccW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            a_neg_q <= a_neg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
